gist_calc_ctrl: RTL and testbench

- Sequencer for the histogram ("gist") datapath of the image pipeline.
- Owns an external dual-port bin RAM and runs one frame job per start pulse: clear all bins, accumulate a pixel stream, then stream the finished histogram out.
- Sits between the pixel source (image/PPM matrix reader) and downstream statistics consumers.
- The RTL counterpart of the gist computation model used in verification.

---
 rtl/gist_pkg.sv | 34 +++
 rtl/gist_rmw.sv | 82 ++++++++
 rtl/gist_calc_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_gist_calc_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gist_pkg.sv
// gist_pkg: shared types for the histogram ("gist") sequencer.
//
// Contents:
//   gist_state_t   - job sequencer states
//   gist_wr_t      - forwarding register of the read-modify-write pipeline,
//                    sized for the widest supported configuration
//                    (BIN_W <= GIST_MAX_BIN_W, CNT_W <= GIST_MAX_CNT_W);
//                    users zero-extend into it
//   gist_bin_count - number of bins for a given BIN_W (2^BIN_W)
package gist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACC,
    DRAIN,
    READ,
    DONE
  } gist_state_t;

  localparam int GIST_MAX_BIN_W = 16;
  localparam int GIST_MAX_CNT_W = 32;

  typedef struct packed {
    logic                      vld;
    logic [GIST_MAX_BIN_W-1:0] addr;
    logic [GIST_MAX_CNT_W-1:0] data;
  } gist_wr_t;

  function automatic int unsigned gist_bin_count(input int unsigned bin_w);
    return 32'd1 << bin_w;
  endfunction

endpackage

// File: rtl/gist_rmw.sv
// gist_rmw: two-stage read-modify-write pipeline that increments one bin per
// accepted pixel.
//
// S0 (accept cycle) issues the bin read; S1 adds one to the returned count and
// writes it back. The bin RAM is read-first, so a pixel hitting the same bin
// as the pixel directly before it would read a stale count; the previous
// write is kept in wr_q and forwarded in that case. Two pixels further apart
// see the committed value from the RAM itself.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   pix_accept     a pixel is accepted this cycle (S0)
//   pix_bin        bin of the accepted pixel
//   rd_addr        bin RAM read address (0 when no pixel is accepted)
//   rd_data        bin RAM read data, one cycle after rd_addr
//   wr_en/addr/data  bin RAM write port (S1)
//   sat_hit        (GIST_SAT_EN only) the written count reached the maximum
//
// Optional feature macro: GIST_SAT_EN (saturating instead of wrapping count).
module gist_rmw
  import gist_pkg::*;
#(
  parameter int BIN_W = 6,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_accept,
  input  logic [BIN_W-1:0] pix_bin,
  output logic [BIN_W-1:0] rd_addr,
  input  logic [CNT_W-1:0] rd_data,
  output logic             wr_en,
  output logic [BIN_W-1:0] wr_addr,
  output logic [CNT_W-1:0] wr_data
`ifdef GIST_SAT_EN
  ,
  output logic             sat_hit
`endif
);

  logic                      s1_vld;
  logic [BIN_W-1:0]          s1_bin;
  gist_wr_t                  wr_q;
  logic                      fwd_hit;
  logic [GIST_MAX_CNT_W-1:0] src;
  logic [CNT_W-1:0]          new_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_bin <= '0;
      wr_q   <= '0;
    end else begin
      s1_vld     <= pix_accept;
      s1_bin     <= pix_bin;
      wr_q.vld   <= s1_vld;
      wr_q.addr  <= GIST_MAX_BIN_W'(s1_bin);
      wr_q.data  <= GIST_MAX_CNT_W'(new_cnt);
    end
  end

  always_comb begin
    rd_addr = pix_accept ? pix_bin : '0;
    fwd_hit = wr_q.vld && (wr_q.addr == GIST_MAX_BIN_W'(s1_bin));
    src     = fwd_hit ? wr_q.data : GIST_MAX_CNT_W'(rd_data);
`ifdef GIST_SAT_EN
    // Clamp at the all-ones count; the flag reports any write that lands there.
    if (src[CNT_W-1:0] == {CNT_W{1'b1}}) begin
      new_cnt = src[CNT_W-1:0];
    end else begin
      new_cnt = CNT_W'(src + GIST_MAX_CNT_W'(1));
    end
    sat_hit = s1_vld && (new_cnt == {CNT_W{1'b1}});
`else
    new_cnt = CNT_W'(src + GIST_MAX_CNT_W'(1));
`endif
    wr_en   = s1_vld;
    wr_addr = s1_vld ? s1_bin : '0;
    wr_data = s1_vld ? new_cnt : '0;
  end

endmodule

// File: rtl/gist_calc_ctrl.sv
// gist_calc_ctrl: histogram sequencer. One job per accepted start pulse:
// clear every bin of the external bin RAM, accumulate frame_len pixels, let
// the update pipeline drain, then stream all bins out 0..2^BIN_W-1.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, frame_len  job request; frame_len latched on accepted start
//   busy, done        job in progress / one-cycle end-of-job pulse
//   pix_valid/ready/data   pixel stream in (accepted only while accumulating)
//   ram_raddr, ram_rdata   bin RAM read port (1-cycle latency, read-first)
//   ram_we/waddr/wdata     bin RAM write port
//   bin_valid/ready/idx/cnt/last   histogram stream out
//   sat_flag          (GIST_SAT_EN only) sticky: some bin saturated this job
//
// Optional feature macro: GIST_SAT_EN. Undefined: counts wrap modulo 2^CNT_W
// and sat_flag does not exist. Defined: counts saturate and sat_flag is present.
module gist_calc_ctrl
  import gist_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int BIN_W = 6,
  parameter int CNT_W = 16,
  parameter int LEN_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  output logic             busy,
  output logic             done,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [PIX_W-1:0] pix_data,
  output logic [BIN_W-1:0] ram_raddr,
  input  logic [CNT_W-1:0] ram_rdata,
  output logic             ram_we,
  output logic [BIN_W-1:0] ram_waddr,
  output logic [CNT_W-1:0] ram_wdata,
  output logic             bin_valid,
  input  logic             bin_ready,
  output logic [BIN_W-1:0] bin_idx,
  output logic [CNT_W-1:0] bin_cnt,
  output logic             bin_last
`ifdef GIST_SAT_EN
  ,
  output logic             sat_flag
`endif
);

  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(gist_bin_count(BIN_W) - 1);

  gist_state_t      state, state_next;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] acc_cnt;
  logic [BIN_W-1:0] clr_cnt;
  logic             drain_cnt;
  logic [BIN_W-1:0] rd_idx;
  logic             rd_inflight;
  logic             rd_end;
  logic             rd_issue;
  logic             start_accept;
  logic             pix_accept;
  logic [BIN_W-1:0] pix_bin;
  logic [BIN_W-1:0] rmw_raddr;
  logic             rmw_we;
  logic [BIN_W-1:0] rmw_waddr;
  logic [CNT_W-1:0] rmw_wdata;
`ifdef GIST_SAT_EN
  logic             rmw_sat_hit;
`endif

  assign pix_bin = pix_data[PIX_W-1 -: BIN_W];

  gist_rmw #(
    .BIN_W(BIN_W),
    .CNT_W(CNT_W)
  ) u_rmw (
    .clk       (clk),
    .rst       (rst),
    .pix_accept(pix_accept),
    .pix_bin   (pix_bin),
    .rd_addr   (rmw_raddr),
    .rd_data   (ram_rdata),
    .wr_en     (rmw_we),
    .wr_addr   (rmw_waddr),
    .wr_data   (rmw_wdata)
`ifdef GIST_SAT_EN
    ,
    .sat_hit   (rmw_sat_hit)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    pix_ready  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        busy = 1'b1;
        if (clr_cnt == LAST_BIN) begin
          state_next = (len_q == '0) ? DRAIN : ACC;
        end
      end
      ACC: begin
        busy      = 1'b1;
        pix_ready = (acc_cnt < len_q);
        if (pix_valid && pix_ready && (acc_cnt == len_q - LEN_W'(1))) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt) begin
          state_next = READ;
        end
      end
      READ: begin
        busy = 1'b1;
        if (bin_valid && bin_ready && bin_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign start_accept = (state == IDLE) && start;
  assign pix_accept   = pix_valid && pix_ready;

  // A bin being handed off this cycle frees the output register, which lets
  // the next read overlap the handshake and keeps readout at 1 bin / 2 cycles.
  assign rd_issue = (state == READ) && !rd_inflight && !rd_end &&
                    (!bin_valid || bin_ready);

  always_comb begin
    ram_raddr = rd_issue ? rd_idx : rmw_raddr;
    ram_we    = (state == CLEAR) || rmw_we;
    ram_waddr = (state == CLEAR) ? clr_cnt : rmw_waddr;
    ram_wdata = (state == CLEAR) ? '0 : rmw_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q       <= '0;
      acc_cnt     <= '0;
      clr_cnt     <= '0;
      drain_cnt   <= 1'b0;
      rd_idx      <= '0;
      rd_inflight <= 1'b0;
      rd_end      <= 1'b0;
      bin_valid   <= 1'b0;
      bin_idx     <= '0;
      bin_cnt     <= '0;
      bin_last    <= 1'b0;
    end else begin
      if (start_accept) begin
        len_q   <= frame_len;
        acc_cnt <= '0;
        clr_cnt <= '0;
        rd_idx  <= '0;
        rd_end  <= 1'b0;
      end
      if (state == CLEAR) begin
        clr_cnt <= clr_cnt + BIN_W'(1);
      end
      if (pix_accept) begin
        acc_cnt <= acc_cnt + LEN_W'(1);
      end
      if (state == DRAIN) begin
        drain_cnt <= ~drain_cnt;
      end
      rd_inflight <= rd_issue;
      if (rd_inflight) begin
        bin_valid <= 1'b1;
        bin_cnt   <= ram_rdata;
        bin_idx   <= rd_idx;
        bin_last  <= (rd_idx == LAST_BIN);
        rd_idx    <= rd_idx + BIN_W'(1);
        if (rd_idx == LAST_BIN) begin
          rd_end <= 1'b1;
        end
      end else if (bin_valid && bin_ready) begin
        bin_valid <= 1'b0;
        bin_last  <= 1'b0;
      end
    end
  end

`ifdef GIST_SAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_flag <= 1'b0;
    end else if (start_accept) begin
      sat_flag <= 1'b0;
    end else if (rmw_sat_hit) begin
      sat_flag <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gist_calc_ctrl.sv
// tb_gist_calc_ctrl: directed bench for gist_calc_ctrl.
// Two DUTs share clock, reset and the pixel/result inputs: "a" uses the
// default widths, "b" uses CNT_W=4 for the wrap/saturation scenario. Each has
// its own read-first bin RAM preloaded with garbage so that CLEAR is exercised.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_gist_calc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [19:0] frame_len;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        bin_ready;
  bit          sel;

  logic        a_start, a_busy, a_done, a_pix_ready, a_we, a_bin_valid, a_bin_last;
  logic [5:0]  a_raddr, a_waddr, a_bin_idx;
  logic [15:0] a_rdata, a_wdata, a_bin_cnt;
  logic        b_start, b_busy, b_done, b_pix_ready, b_we, b_bin_valid, b_bin_last;
  logic [5:0]  b_raddr, b_waddr, b_bin_idx;
  logic [3:0]  b_rdata, b_wdata, b_bin_cnt;
`ifdef GIST_SAT_EN
  logic        a_sat, b_sat;
`endif

  logic [15:0] a_mem [64];
  logic [3:0]  b_mem [64];

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [7:0]  pix_buf [64];
  int          hist [64];
  int          exp_h [64];
  int          order_err, last_err, done_cnt, gaps;
  bit          timed_out;

  logic        m_pix_ready, m_bin_valid, m_bin_last, m_done;
  logic [5:0]  m_bin_idx;
  logic [15:0] m_bin_cnt;

  assign a_start     = start & ~sel;
  assign b_start     = start & sel;
  assign m_pix_ready = sel ? b_pix_ready : a_pix_ready;
  assign m_bin_valid = sel ? b_bin_valid : a_bin_valid;
  assign m_bin_last  = sel ? b_bin_last : a_bin_last;
  assign m_done      = sel ? b_done : a_done;
  assign m_bin_idx   = sel ? b_bin_idx : a_bin_idx;
  assign m_bin_cnt   = sel ? {12'd0, b_bin_cnt} : a_bin_cnt;

  always #5 clk = ~clk;

  gist_calc_ctrl dut_a (
    .clk(clk), .rst(rst), .start(a_start), .frame_len(frame_len),
    .busy(a_busy), .done(a_done), .pix_valid(pix_valid), .pix_ready(a_pix_ready),
    .pix_data(pix_data), .ram_raddr(a_raddr), .ram_rdata(a_rdata), .ram_we(a_we),
    .ram_waddr(a_waddr), .ram_wdata(a_wdata), .bin_valid(a_bin_valid),
    .bin_ready(bin_ready), .bin_idx(a_bin_idx), .bin_cnt(a_bin_cnt),
    .bin_last(a_bin_last)
`ifdef GIST_SAT_EN
    , .sat_flag(a_sat)
`endif
  );

  gist_calc_ctrl #(.CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .frame_len(frame_len),
    .busy(b_busy), .done(b_done), .pix_valid(pix_valid), .pix_ready(b_pix_ready),
    .pix_data(pix_data), .ram_raddr(b_raddr), .ram_rdata(b_rdata), .ram_we(b_we),
    .ram_waddr(b_waddr), .ram_wdata(b_wdata), .bin_valid(b_bin_valid),
    .bin_ready(bin_ready), .bin_idx(b_bin_idx), .bin_cnt(b_bin_cnt),
    .bin_last(b_bin_last)
`ifdef GIST_SAT_EN
    , .sat_flag(b_sat)
`endif
  );

  initial begin
    for (int i = 0; i < 64; i++) begin
      a_mem[i] = 16'hBEEF;
      b_mem[i] = 4'hA;
    end
    a_rdata = '0;
    b_rdata = '0;
  end

  // read-first: the read samples the old contents before the write lands
  always @(posedge clk) begin
    a_rdata <= a_mem[a_raddr];
    if (a_we) a_mem[a_waddr] <= a_wdata;
    b_rdata <= b_mem[b_raddr];
    if (b_we) b_mem[b_waddr] <= b_wdata;
  end

  task automatic start_job(input logic [19:0] len);
    frame_len = len;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input int n);
    int  i = 0;
    int  cyc = 0;
    bit  rdy;
    bit  seen = 0;
    gaps = 0;
    while (i < n && cyc < 1000) begin
      pix_valid = 1'b1;
      pix_data  = pix_buf[i];
      rdy = m_pix_ready;
      @(negedge clk);
      cyc++;
      if (rdy) begin
        i++;
        seen = 1;
      end else if (seen) begin
        gaps++;
      end
    end
    pix_valid = 1'b0;
    if (i < n) timed_out = 1;
  endtask

  task automatic collect(input int k0);
    int k = k0;
    int cyc = 0;
    if (k0 == 0) begin
      order_err = 0;
      last_err  = 0;
      for (int i = 0; i < 64; i++) hist[i] = -1;
    end
    bin_ready = 1'b1;
    while (k < 64 && cyc < 1000) begin
      if (m_bin_valid) begin
        hist[k] = int'(m_bin_cnt);
        if (int'(m_bin_idx) != k) order_err++;
        if (m_bin_last != (k == 63)) last_err++;
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    if (k < 64) timed_out = 1;
    done_cnt = 0;
    for (int j = 0; j < 5; j++) begin
      if (m_done) done_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({a_busy, a_done, a_pix_ready, a_we, a_bin_valid, a_bin_last} !== 6'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got %b expected 000000",
               {a_busy, a_done, a_pix_ready, a_we, a_bin_valid, a_bin_last});
    end
    tests_run++;
    if ({a_raddr, a_waddr, a_wdata, a_bin_idx, a_bin_cnt} !== 50'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data: raddr %0d waddr %0d wdata %0d idx %0d cnt %0d expected all 0",
               a_raddr, a_waddr, a_wdata, a_bin_idx, a_bin_cnt);
    end
  endtask

  task automatic check_job(input string name, input int exp_done);
    tests_run++;
    if (timed_out) begin
      tests_failed++;
      $display("[TB] FAIL %s timeout: got timeout expected completion", name);
    end
    tests_run++;
    if (order_err != 0 || last_err != 0) begin
      tests_failed++;
      $display("[TB] FAIL %s order/last: got %0d/%0d errors expected 0/0", name, order_err, last_err);
    end
    tests_run++;
    if (done_cnt != exp_done) begin
      tests_failed++;
      $display("[TB] FAIL %s done: got %0d pulses expected %0d", name, done_cnt, exp_done);
    end
    for (int b = 0; b < 64; b++) begin
      tests_run++;
      if (hist[b] != exp_h[b]) begin
        tests_failed++;
        $display("[TB] FAIL %s bin %0d: got %0d expected %0d", name, b, hist[b], exp_h[b]);
      end
    end
  endtask

  task automatic clear_exp;
    for (int i = 0; i < 64; i++) exp_h[i] = 0;
    timed_out = 0;
  endtask

  task automatic test_basic;
    sel = 0;
    clear_exp();
    pix_buf[0] = 8'h00; pix_buf[1] = 8'h04; pix_buf[2] = 8'hFF; pix_buf[3] = 8'h05;
    exp_h[0] = 1; exp_h[1] = 2; exp_h[63] = 1;
    start_job(20'd4);
    tests_run++;
    if (a_busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL basic_busy: got %b expected 1", a_busy);
    end
    feed(4);
    collect(0);
    check_job("basic", 1);
    tests_run++;
    if (a_busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL basic_idle: busy got %b expected 0", a_busy);
    end
  endtask

  task automatic test_back_to_back;
    sel = 0;
    clear_exp();
    for (int i = 0; i < 16; i++) pix_buf[i] = 8'h80;
    exp_h[32] = 16;
    start_job(20'd16);
    feed(16);
    tests_run++;
    if (gaps != 0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_ready_gaps: got %0d expected 0", gaps);
    end
    collect(0);
    check_job("b2b", 1);
  endtask

  task automatic test_alternating;
    sel = 0;
    clear_exp();
    for (int i = 0; i < 16; i++) pix_buf[i] = (i % 2 == 0) ? 8'h80 : 8'h84;
    exp_h[32] = 8; exp_h[33] = 8;
    start_job(20'd16);
    feed(16);
    collect(0);
    check_job("alt", 1);
  endtask

  task automatic test_zero_len;
    int rdy_seen = 0;
    sel = 0;
    clear_exp();
    bin_ready = 1'b0;
    start_job(20'd0);
    // second start while busy with a different length must be ignored
    start_job(20'd3);
    tests_run++;
    if (a_busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL zero_busy_after_start: got %b expected 1", a_busy);
    end
    for (int c = 0; c < 70; c++) begin
      if (a_pix_ready) rdy_seen++;
      @(negedge clk);
    end
    tests_run++;
    if (rdy_seen != 0) begin
      tests_failed++;
      $display("[TB] FAIL zero_pix_ready: got %0d ready cycles expected 0", rdy_seen);
    end
    collect(0);
    check_job("zero", 1);
    repeat (5) @(negedge clk);
    tests_run++;
    if (a_busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL zero_no_second_job: busy got %b expected 0", a_busy);
    end
  endtask

  task automatic test_reset_and_stall;
    bit          held = 0;
    logic [5:0]  h_idx;
    logic [15:0] h_cnt;
    sel = 0;
    for (int i = 0; i < 10; i++) pix_buf[i] = 8'h40;
    timed_out = 0;
    start_job(20'd10);
    feed(3);
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({a_busy, a_done, a_pix_ready, a_we, a_bin_valid, a_bin_last} !== 6'b0) begin
      tests_failed++;
      $display("[TB] FAIL midacc_reset_flags: got %b expected 000000",
               {a_busy, a_done, a_pix_ready, a_we, a_bin_valid, a_bin_last});
    end
    tests_run++;
    if ({a_raddr, a_waddr, a_wdata} !== 28'd0) begin
      tests_failed++;
      $display("[TB] FAIL midacc_reset_ram: raddr %0d waddr %0d wdata %0d expected 0",
               a_raddr, a_waddr, a_wdata);
    end
    rst = 1'b0;
    @(negedge clk);

    clear_exp();
    pix_buf[0] = 8'h10; pix_buf[1] = 8'h10; pix_buf[2] = 8'h20;
    exp_h[4] = 2; exp_h[8] = 1;
    order_err = 0;
    last_err  = 0;
    for (int i = 0; i < 64; i++) hist[i] = -1;
    start_job(20'd3);
    feed(3);
    bin_ready = 1'b1;
    for (int c = 0; c < 500; c++) begin
      if (a_bin_valid && a_bin_idx == 6'd5) begin
        bin_ready = 1'b0;
        held = 1;
        break;
      end
      if (a_bin_valid) hist[a_bin_idx] = int'(a_bin_cnt);
      @(negedge clk);
    end
    tests_run++;
    if (!held) begin
      tests_failed++;
      $display("[TB] FAIL stall_reach: got no bin 5 expected bin 5 valid");
    end
    h_idx = a_bin_idx;
    h_cnt = a_bin_cnt;
    repeat (10) begin
      @(negedge clk);
      tests_run++;
      if (!a_bin_valid || a_bin_idx !== h_idx || a_bin_cnt !== h_cnt) begin
        tests_failed++;
        $display("[TB] FAIL stall_hold: got v=%b idx %0d cnt %0d expected v=1 idx %0d cnt %0d",
                 a_bin_valid, a_bin_idx, a_bin_cnt, h_idx, h_cnt);
      end
    end
    collect(5);
    check_job("stall", 1);
  endtask

  task automatic test_wrap;
    sel = 1;
    clear_exp();
    for (int i = 0; i < 17; i++) pix_buf[i] = 8'h00;
`ifdef GIST_SAT_EN
    exp_h[0] = 15;
`else
    exp_h[0] = 1;
`endif
    start_job(20'd17);
    feed(17);
    collect(0);
    check_job("wrap", 1);
`ifdef GIST_SAT_EN
    tests_run++;
    if (b_sat !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL sat_flag_b: got %b expected 1", b_sat);
    end
    tests_run++;
    if (a_sat !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL sat_flag_a: got %b expected 0", a_sat);
    end
`endif
    sel = 0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    frame_len = '0;
    pix_valid = 1'b0;
    pix_data = '0;
    bin_ready = 1'b0;
    sel = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_alternating();
    test_zero_len();
    test_reset_and_stall();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
